cpu_run_ctrl: RTL and testbench

Synthesizable run controller that sequences one program execution on the lab CPU.
- Accepts a stream of instruction words and writes them into instruction memory.
- Optionally initialises the register file with R[i]=i.
- Holds the CPU in reset for a programmable time, then releases it.
- Counts execution cycles and stops on a halt instruction, a timeout or an abort, reporting a status code.
- Replaces fixed-delay stop logic and memory-file preloading in simulation, and works on FPGA.

---
 rtl/cpu_run_ctrl_if.sv | 14 +
 rtl/cpu_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Program-load stream between the host/loader and the run controller.
interface cpu_run_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (output ld_valid, ld_addr, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_addr, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads a program into imem, optionally seeds R[i]=i, holds
// the CPU in reset, releases it and stops on halt, timeout or abort.
module cpu_run_ctrl #(
  parameter int                 ADDR_W     = 8,
  parameter int                 DATA_W     = 32,
  parameter int                 NUM_REGS   = 32,
  parameter int                 RF_AW      = 5,
  parameter int                 CYC_W      = 16,
  parameter logic [DATA_W-1:0]  HALT_WORD  = 32'hFFFF_FFFF,
  parameter int                 RESET_HOLD = 4,
  parameter int                 INIT_REGS  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CYC_W-1:0]  max_cycles,
  cpu_run_ctrl_if.slave     ld,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              cpu_reset,
  input  logic [DATA_W-1:0] cpu_instr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CYC_W-1:0]  cycle_count
);
  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RINIT, RSTHOLD, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [CYC_W-1:0]  max_q, max_n, cnt_n, cnt_inc;
  logic [1:0]        status_n;
  logic              rf_we_n;
  logic [RF_AW-1:0]  rf_addr_n;
  logic              xfer, halt_hit, tmo_hit;

  // Load handshake is a pure state decode so the loader sees ready immediately.
  assign ld.ld_ready  = (state == LOAD);
  assign xfer         = ld.ld_valid & ld.ld_ready;
  assign imem_we      = xfer;
  assign imem_addr    = ld.ld_addr;
  assign imem_wdata   = ld.ld_data;
  assign busy         = (state == LOAD) || (state == RINIT) || (state == RSTHOLD) || (state == RUN);
  assign done         = (state == DONE);

  assign halt_hit = (cpu_instr == HALT_WORD);
  // Widened compare so a saturated counter can never wrap into a false match.
  assign tmo_hit  = (max_q != '0) &&
                    ((CYC_W+1)'(cycle_count) + (CYC_W+1)'(1) == (CYC_W+1)'(max_q));
  assign cnt_inc  = (&cycle_count) ? cycle_count : cycle_count + CYC_W'(1);

  // Next-state and next-register values; abort overrides everything while busy.
  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    max_n     = max_q;
    cnt_n     = cycle_count;
    status_n  = status;
    rf_we_n   = 1'b0;
    rf_addr_n = rf_addr;
    if (busy && abort) begin
      state_n  = DONE;
      status_n = 2'b11;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state_n  = LOAD;
          status_n = 2'b00;
          cnt_n    = '0;
          max_n    = max_cycles;
        end
        LOAD: if (xfer && ld.ld_last) begin
          if (INIT_REGS != 0) begin
            state_n   = RINIT;
            rf_we_n   = 1'b1;
            rf_addr_n = '0;
          end else begin
            state_n = RSTHOLD;
            hold_n  = '0;
          end
        end
        RINIT: if (rf_addr == RF_AW'(NUM_REGS-1)) begin
          state_n = RSTHOLD;
          hold_n  = '0;
        end else begin
          rf_we_n   = 1'b1;
          rf_addr_n = rf_addr + RF_AW'(1);
        end
        RSTHOLD: if (hold_cnt == HW'(RESET_HOLD-1)) state_n = RUN;
                 else hold_n = hold_cnt + HW'(1);
        RUN: begin
          cnt_n = cnt_inc;
          if (halt_hit) begin
            state_n  = DONE;
            status_n = 2'b01;
          end else if (tmo_hit) begin
            state_n  = DONE;
            status_n = 2'b10;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Registered outputs and internal counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      max_q       <= '0;
      cycle_count <= '0;
      status      <= 2'b00;
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
      cpu_reset   <= 1'b1;
    end else begin
      hold_cnt    <= hold_n;
      max_q       <= max_n;
      cycle_count <= cnt_n;
      status      <= status_n;
      rf_we       <= rf_we_n;
      rf_addr     <= rf_addr_n;
      rf_wdata    <= DATA_W'(rf_addr_n);
      cpu_reset   <= (state_n != RUN);
    end
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with hand-computed expectations.
module tb_cpu_run_ctrl;
  logic        clock = 1'b0;
  logic        reset, start, abort;
  logic [15:0] max_cycles;
  logic        imem_we, rf_we, cpu_reset, busy, done;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata, rf_wdata, cpu_instr;
  logic [4:0]  rf_addr;
  logic [1:0]  status;
  logic [15:0] cycle_count;
  int checks = 0;
  int errors = 0;

  cpu_run_ctrl_if #(.ADDR_W(8), .DATA_W(32)) ld_if ();

  cpu_run_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .max_cycles(max_cycles), .ld(ld_if),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .cpu_reset(cpu_reset), .cpu_instr(cpu_instr),
    .busy(busy), .done(done), .status(status), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Start a run with a one-word program and advance to the first RUN cycle.
  task automatic start_run(input logic [15:0] mx);
    int n;
    start = 1'b1; max_cycles = mx; step(); start = 1'b0;
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 8'h00; ld_if.ld_data = 32'h13; ld_if.ld_last = 1'b1;
    step();
    ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    n = 0;
    while (cpu_reset !== 1'b0 && n < 60) begin step(); n++; end
    checks++;
    if (cpu_reset !== 1'b0) begin errors++; $display("FAIL start_run_reach_run cpu_reset=%b required 0", cpu_reset); end
  endtask

  task automatic test_reset();
    reset = 1'b1; #12;
    checks++;
    if ({cpu_reset, ld_if.ld_ready, imem_we, rf_we, busy, done} !== 6'b100000) begin
      errors++; $display("FAIL reset_flags got %b required 100000", {cpu_reset, ld_if.ld_ready, imem_we, rf_we, busy, done});
    end
    checks++;
    if (status !== 2'b00 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL reset_status status=%b count=%0d required 00/0", status, cycle_count);
    end
    @(negedge clock); reset = 1'b0; step();
  endtask

  task automatic test_load_halt();
    logic [31:0] words [3];
    words[0] = 32'h0000_0093; words[1] = 32'h0010_0113; words[2] = 32'hFFFF_FFFF;
    start = 1'b1; max_cycles = 16'd0; step(); start = 1'b0;
    checks++;
    if (ld_if.ld_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL load_enter ready=%b busy=%b required 1/1", ld_if.ld_ready, busy); end
    for (int w = 0; w < 3; w++) begin
      ld_if.ld_valid = 1'b1; ld_if.ld_addr = 8'(w); ld_if.ld_data = words[w]; ld_if.ld_last = (w == 2);
      #1;
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 8'(w) || imem_wdata !== words[w]) begin
        errors++; $display("FAIL load_write%0d we=%b addr=%h data=%h required 1/%h/%h", w, imem_we, imem_addr, imem_wdata, 8'(w), words[w]);
      end
      step();
    end
    ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (rf_we !== 1'b1 || rf_addr !== 5'(i) || rf_wdata !== 32'(i)) begin
        errors++; $display("FAIL rinit_idx%0d we=%b addr=%0d data=%0d required 1/%0d/%0d", i, rf_we, rf_addr, rf_wdata, i, i);
      end
      step();
    end
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rinit_end rf_we=%b required 0", rf_we); end
    for (int h = 0; h < 4; h++) begin
      checks++;
      if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rsthold%0d cpu_reset=%b required 1", h, cpu_reset); end
      step();
    end
    checks++;
    if (cpu_reset !== 1'b0) begin errors++; $display("FAIL run_release cpu_reset=%b required 0", cpu_reset); end
    cpu_instr = 32'hFFFF_FFFF; step(); cpu_instr = 32'h0;
    checks++;
    if (done !== 1'b1 || status !== 2'b01 || cycle_count !== 16'd1 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL halt_first done=%b status=%b count=%0d rst=%b required 1/01/1/1", done, status, cycle_count, cpu_reset);
    end
  endtask

  task automatic test_halt_timing();
    start_run(16'd0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cycle_count !== 16'(k)) begin errors++; $display("FAIL run_count%0d got %0d required %0d", k, cycle_count, k); end
      step();
    end
    cpu_instr = 32'hFFFF_FFFF; step(); cpu_instr = 32'h0;
    checks++;
    if (done !== 1'b1 || status !== 2'b01 || cycle_count !== 16'd7 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL halt_timing done=%b status=%b count=%0d rst=%b required 1/01/7/1", done, status, cycle_count, cpu_reset);
    end
  endtask

  task automatic test_timeout();
    int n;
    start_run(16'd10);
    n = 0;
    while (done !== 1'b1 && n < 30) begin step(); n++; end
    checks++;
    if (n != 10 || status !== 2'b10 || cycle_count !== 16'd10) begin
      errors++; $display("FAIL timeout cycles=%0d status=%b count=%0d required 10/10/10", n, status, cycle_count);
    end
  endtask

  task automatic test_halt_vs_timeout();
    start_run(16'd5);
    repeat (4) step();
    cpu_instr = 32'hFFFF_FFFF; step(); cpu_instr = 32'h0;
    checks++;
    if (done !== 1'b1 || status !== 2'b01 || cycle_count !== 16'd5) begin
      errors++; $display("FAIL halt_priority done=%b status=%b count=%0d required 1/01/5", done, status, cycle_count);
    end
  endtask

  task automatic test_abort_run();
    start_run(16'd0);
    repeat (3) step();
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 2'b11 || cycle_count !== 16'd3 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL abort_run done=%b status=%b count=%0d rst=%b required 1/11/3/1", done, status, cycle_count, cpu_reset);
    end
    ld_if.ld_valid = 1'b1; #1;
    checks++;
    if (imem_we !== 1'b0 || ld_if.ld_ready !== 1'b0) begin errors++; $display("FAIL ld_outside_load we=%b ready=%b required 0/0", imem_we, ld_if.ld_ready); end
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic test_abort_rinit();
    start = 1'b1; max_cycles = 16'd0; step(); start = 1'b0;
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 8'h00; ld_if.ld_data = 32'h13; ld_if.ld_last = 1'b1;
    step(); ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    repeat (12) step();
    checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd12) begin errors++; $display("FAIL rinit_at12 we=%b addr=%0d required 1/12", rf_we, rf_addr); end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 2'b11 || rf_we !== 1'b0) begin
      errors++; $display("FAIL abort_rinit done=%b status=%b rf_we=%b required 1/11/0", done, status, rf_we);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (status !== 2'b00 || cycle_count !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart status=%b count=%0d busy=%b required 00/0/1", status, cycle_count, busy);
    end
  endtask

  task automatic test_backpressure_reset();
    ld_if.ld_valid = 1'b0; start = 1'b1; #1;
    checks++;
    if (imem_we !== 1'b0) begin errors++; $display("FAIL gap0 imem_we=%b required 0", imem_we); end
    step();
    checks++;
    if (ld_if.ld_ready !== 1'b1 || status !== 2'b00) begin errors++; $display("FAIL start_busy ready=%b status=%b required 1/00", ld_if.ld_ready, status); end
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 8'h05; ld_if.ld_data = 32'hA5A5_0001; #1;
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h05) begin errors++; $display("FAIL bp_write1 we=%b addr=%h required 1/05", imem_we, imem_addr); end
    step();
    ld_if.ld_valid = 1'b0; #1;
    checks++;
    if (imem_we !== 1'b0) begin errors++; $display("FAIL gap1 imem_we=%b required 0", imem_we); end
    step();
    ld_if.ld_valid = 1'b1; ld_if.ld_addr = 8'h06; ld_if.ld_data = 32'hFFFF_FFFF; ld_if.ld_last = 1'b1; #1;
    checks++;
    if (imem_we !== 1'b1 || imem_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_write2 we=%b data=%h required 1/ffffffff", imem_we, imem_wdata); end
    step(); ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0;
    step(); start = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_addr !== 5'd1) begin errors++; $display("FAIL start_in_rinit we=%b addr=%0d required 1/1", rf_we, rf_addr); end
    repeat (40) step();
    step(); step();
    checks++;
    if (cpu_reset !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midrun rst=%b busy=%b required 0/1", cpu_reset, busy); end
    #2 reset = 1'b1; #1;
    checks++;
    if ({cpu_reset, busy, done, rf_we, ld_if.ld_ready} !== 5'b10000 || status !== 2'b00 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL async_reset flags=%b status=%b count=%0d required 10000/00/0", {cpu_reset, busy, done, rf_we, ld_if.ld_ready}, status, cycle_count);
    end
    @(negedge clock); reset = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL abort_idle busy=%b done=%b status=%b required 0/0/00", busy, done, status); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; max_cycles = '0; cpu_instr = '0;
    ld_if.ld_valid = 1'b0; ld_if.ld_addr = '0; ld_if.ld_data = '0; ld_if.ld_last = 1'b0;
    test_reset();
    test_load_halt();
    test_halt_timing();
    test_timeout();
    test_halt_vs_timeout();
    test_abort_run();
    test_abort_rinit();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
